// File: rtl/mc_main_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control FSM: opcodes, states,
// datapath mux selects and the decoded control word.
package mc_main_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALU control decoder expects exactly these alu_op values.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_EQ    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_A      = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13,
    S_JR     = 4'd14
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode of FSM state (plus mem_ready for the handshake-gated
// strobes) into the full datapath control word.
module mc_ctrl_decode
  import mc_main_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.iord      = 1'b0;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PCS_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMMSH;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RT;
        o_ctrl.mem_to_reg = WB_MDR;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RD;
        o_ctrl.mem_to_reg = WB_ALUOUT;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALU_EQ;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCS_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_ADDIWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RT;
        o_ctrl.mem_to_reg = WB_ALUOUT;
        o_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCS_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCS_JUMP;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RA;
        o_ctrl.mem_to_reg = WB_PC;
        o_ctrl.instr_done = 1'b1;
      end
      S_JR: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCS_A;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM: state register, next-state sequencing,
// sticky illegal-opcode flag; outputs come from mc_ctrl_decode.
module mc_main_ctrl
  import mc_main_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       jr,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e r_state;
  state_e w_next;
  logic   r_illegal_op;
  logic   w_opcode_legal;
  ctrl_t  w_ctrl;

  assign w_opcode_legal = (opcode == OP_R)   || (opcode == OP_LW)  ||
                          (opcode == OP_SW)  || (opcode == OP_BEQ) ||
                          (opcode == OP_J)   || (opcode == OP_JAL) ||
                          (opcode == OP_ADDI);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = jr ? S_JR : S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB,
      S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_illegal_op <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && !w_opcode_legal) r_illegal_op <= 1'b1;
    end
  end

  mc_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign iord          = w_ctrl.iord;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign reg_write     = w_ctrl.reg_write;
  assign reg_dst       = w_ctrl.reg_dst;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign instr_done    = w_ctrl.instr_done;
  assign illegal_op    = r_illegal_op;
  assign state         = r_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench: scripts instructions (with random stalls) cycle by
// cycle and compares every output against a table-driven reference.
module tb_mc_main_ctrl;
  import mc_main_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       jr;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;
  } obs_t;

  obs_t w_obs;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_ill = 1'b0;

  always #5 clk = ~clk;

  mc_main_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .jr(jr), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  assign w_obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal_op, state};

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b000011, 6'b001000};
  endfunction

  // Output table written straight from the per-state output rules.
  function automatic obs_t exp_obs(input state_e s, input logic mr, input logic ill);
    obs_t e;
    e = '0;
    e.state = s;
    e.illegal_op = ill;
    case (s)
      S_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
      S_DECODE: e.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      S_MEMRD:  begin e.mem_read = 1; e.iord = 1; end
      S_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; e.instr_done = 1; end
      S_MEMWR:  begin e.mem_write = 1; e.iord = 1; e.instr_done = mr; end
      S_EXEC:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      S_ALUWB:  begin e.reg_write = 1; e.reg_dst = 2'b01; e.instr_done = 1; end
      S_BRANCH: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                      e.pc_source = 2'b01; e.instr_done = 1; end
      S_ADDIWB: begin e.reg_write = 1; e.instr_done = 1; end
      S_JUMP:   begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
      S_JAL:    begin e.pc_write = 1; e.pc_source = 2'b10; e.reg_write = 1;
                      e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.instr_done = 1; end
      S_JR:     begin e.pc_write = 1; e.pc_source = 2'b11; e.instr_done = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  // One clock cycle in which the reference expects the FSM to sit in s.
  task automatic cyc(input state_e s, input logic [5:0] op, input logic mr, input logic j);
    opcode    = op;
    mem_ready = mr;
    jr        = j;
    #2;
    check(s.name(), w_obs, exp_obs(s, mr, m_ill));
    if (s == S_DECODE && !is_legal(op)) m_ill = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic jr_v,
                           input int f_st, input int m_st);
    for (int i = 0; i < f_st; i++) cyc(S_FETCH, op, 1'b0, rb());
    cyc(S_FETCH, op, 1'b1, rb());
    cyc(S_DECODE, op, rb(), rb());
    case (op)
      6'b100011: begin
        cyc(S_MEMADR, op, rb(), rb());
        for (int i = 0; i < m_st; i++) cyc(S_MEMRD, op, 1'b0, rb());
        cyc(S_MEMRD, op, 1'b1, rb());
        cyc(S_MEMWB, op, rb(), rb());
      end
      6'b101011: begin
        cyc(S_MEMADR, op, rb(), rb());
        for (int i = 0; i < m_st; i++) cyc(S_MEMWR, op, 1'b0, rb());
        cyc(S_MEMWR, op, 1'b1, rb());
      end
      6'b000000: begin
        cyc(S_EXEC, op, rb(), jr_v);
        cyc(jr_v ? S_JR : S_ALUWB, op, rb(), rb());
      end
      6'b000100: cyc(S_BRANCH, op, rb(), rb());
      6'b001000: begin
        cyc(S_ADDIEX, op, rb(), rb());
        cyc(S_ADDIWB, op, rb(), rb());
      end
      6'b000010: cyc(S_JUMP, op, rb(), rb());
      6'b000011: cyc(S_JAL, op, rb(), rb());
      default: ;
    endcase
  endtask

  logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b000011, 6'b001000};

  initial begin
    rst_n = 1'b0; opcode = '0; jr = 1'b0; mem_ready = 1'b0;
    #12;
    check("reset", w_obs, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(S_IDLE, 6'b111000, 1'b1, 1'b1);

    // Directed scenarios
    run_instr(6'b100011, 1'b0, 0, 0);   // LW, no stalls
    run_instr(6'b101011, 1'b0, 0, 2);   // SW, two MEMWR stalls
    run_instr(6'b000000, 1'b1, 0, 0);   // JR
    run_instr(6'b000000, 1'b0, 1, 0);   // R-type to ALUWB
    run_instr(6'b000011, 1'b0, 0, 0);   // JAL
    run_instr(6'b111111, 1'b0, 0, 0);   // illegal
    run_instr(6'b001000, 1'b0, 0, 0);   // ADDI with sticky flag

    // Reset asserted in the middle of a MEMRD stall
    cyc(S_FETCH, 6'b100011, 1'b1, 1'b0);
    cyc(S_DECODE, 6'b100011, 1'b0, 1'b0);
    cyc(S_MEMADR, 6'b100011, 1'b0, 1'b0);
    cyc(S_MEMRD, 6'b100011, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_ill = 1'b0;
    check("async_reset", w_obs, '0);
    @(posedge clk); #1;
    check("reset_held", w_obs, '0);
    rst_n = 1'b1;
    cyc(S_IDLE, 6'b100011, 1'b0, 1'b0);
    run_instr(6'b100011, 1'b0, 1, 1);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      op  = (sel < 7) ? ops[sel] : 6'($urandom_range(0, 63));
      run_instr(op, rb(),
                ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3),
                ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
